// File: rtl/traffic_display_driver_if.sv
// Signal bundle between the phase/countdown sequencer and the display driver.
interface traffic_display_driver_if;
  logic [1:0]  out;       // road A phase code
  logic [31:0] counter;   // road A remaining time
  logic [1:0]  out2;      // road B phase code
  logic [31:0] counter2;  // road B remaining time
  logic [3:0]  lamp_a;
  logic [3:0]  lamp_b;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (
    output out, counter, out2, counter2,
    input  lamp_a, lamp_b, seg, an
  );

  modport slave (
    input  out, counter, out2, counter2,
    output lamp_a, lamp_b, seg, an
  );
endinterface

// File: rtl/traffic_display_driver.sv
// Lamp decode with end-of-green blink, shared sequential BCD converter for both
// countdowns, and a 4-digit multiplexed 7-segment scan.
module traffic_display_driver #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_DIV  = 8,
  parameter int unsigned BLINK_LAST = 3
) (
  input logic clk,
  input logic reset,
  traffic_display_driver_if.slave bus
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StStore} conv_state_e;

  // Lamp layout {right, forward, left, stop}; phase code doubles as the bit index.
  function automatic logic [3:0] lamp_decode(logic [1:0] ph, logic [31:0] cnt, logic on);
    logic [3:0] l;
    l = 4'b0001;
    if (ph != 2'b00) begin
      l = 4'b0001 << ph;
      if ((cnt != 32'd0) && (cnt <= 32'(BLINK_LAST)) && !on) l = 4'b0000;
    end
    return l;
  endfunction

  // One double-dabble iteration on {tens, ones, binary}.
  function automatic logic [14:0] dabble_step(logic [14:0] s);
    logic [3:0]  t;
    logic [3:0]  o;
    logic [14:0] r;
    t = s[14:11];
    o = s[10:7];
    if (o >= 4'd5) o = o + 4'd3;
    if (t >= 4'd5) t = t + 4'd3;
    r = {t, o, s[6:0]};
    return {r[13:0], 1'b0};
  endfunction

  // Segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  logic [1:0]        ph_a_q, ph_b_q, last_ph_a_q, last_ph_b_q;
  logic [31:0]       cnt_a_q, cnt_b_q;
  logic              in_valid_q;
  logic [BlinkW-1:0] blink_cnt_a_q, blink_cnt_b_q;
  logic              blink_on_a_q, blink_on_b_q;
  logic [3:0]        lamp_a_q, lamp_b_q;
  logic              chg_a, chg_b;

  conv_state_e       state_q, state_d;
  logic              start, pick_b, need_a, need_b;
  logic              sel_b_q, last_b_q;
  logic [14:0]       shift_q;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        sat_a, sat_b, done_a_q, done_b_q;
  logic [3:0]        tens_a_q, ones_a_q, tens_b_q, ones_b_q;

  logic [ScanW-1:0]  scan_cnt_q;
  logic [1:0]        idx_q, idx_d;
  logic              scan_wrap;
  logic [6:0]        seg_q, seg_d;

  // Input stage: every port is registered before use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ph_a_q     <= '0;
      ph_b_q     <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      in_valid_q <= 1'b0;
    end else begin
      ph_a_q     <= bus.out;
      ph_b_q     <= bus.out2;
      cnt_a_q    <= bus.counter;
      cnt_b_q    <= bus.counter2;
      in_valid_q <= 1'b1;
    end
  end

  assign chg_a = (ph_a_q != last_ph_a_q);
  assign chg_b = (ph_b_q != last_ph_b_q);

  // Blink timers restart on a phase change; lamps register the decoded phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_ph_a_q   <= '0;
      last_ph_b_q   <= '0;
      blink_cnt_a_q <= '0;
      blink_cnt_b_q <= '0;
      blink_on_a_q  <= 1'b1;
      blink_on_b_q  <= 1'b1;
      lamp_a_q      <= '0;
      lamp_b_q      <= '0;
    end else begin
      last_ph_a_q <= ph_a_q;
      last_ph_b_q <= ph_b_q;
      if (chg_a) begin
        blink_cnt_a_q <= '0;
        blink_on_a_q  <= 1'b1;
      end else if (blink_cnt_a_q == BlinkW'(BLINK_DIV - 1)) begin
        blink_cnt_a_q <= '0;
        blink_on_a_q  <= ~blink_on_a_q;
      end else begin
        blink_cnt_a_q <= blink_cnt_a_q + BlinkW'(1);
      end
      if (chg_b) begin
        blink_cnt_b_q <= '0;
        blink_on_b_q  <= 1'b1;
      end else if (blink_cnt_b_q == BlinkW'(BLINK_DIV - 1)) begin
        blink_cnt_b_q <= '0;
        blink_on_b_q  <= ~blink_on_b_q;
      end else begin
        blink_cnt_b_q <= blink_cnt_b_q + BlinkW'(1);
      end
      // A fresh phase starts in the lit half even before the timer register catches up.
      lamp_a_q <= in_valid_q ? lamp_decode(ph_a_q, cnt_a_q, chg_a | blink_on_a_q) : 4'b0000;
      lamp_b_q <= in_valid_q ? lamp_decode(ph_b_q, cnt_b_q, chg_b | blink_on_b_q) : 4'b0000;
    end
  end

  assign sat_a  = (cnt_a_q >= 32'd99) ? 7'd99 : cnt_a_q[6:0];
  assign sat_b  = (cnt_b_q >= 32'd99) ? 7'd99 : cnt_b_q[6:0];
  assign need_a = (sat_a != done_a_q);
  assign need_b = (sat_b != done_b_q);
  // When both roads wait, serve the one not served last.
  assign pick_b = need_b && (!need_a || !last_b_q);

  // Converter state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Converter next state; pending work chains straight from STORE into LOAD.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      StIdle: begin
        if (need_a || need_b) begin
          state_d = StLoad;
          start   = 1'b1;
        end
      end
      StLoad:  state_d = StShift;
      StShift: if (bit_cnt_q == 3'd6) state_d = StStore;
      StStore: begin
        if (need_a || need_b) begin
          state_d = StLoad;
          start   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Converter datapath: latch source, shift seven times, write the digit pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      done_a_q  <= '0;
      done_b_q  <= '0;
      tens_a_q  <= '0;
      ones_a_q  <= '0;
      tens_b_q  <= '0;
      ones_b_q  <= '0;
    end else begin
      if (start) sel_b_q <= pick_b;
      case (state_q)
        StLoad: begin
          bit_cnt_q <= '0;
          last_b_q  <= sel_b_q;
          if (sel_b_q) begin
            done_b_q <= sat_b;
            shift_q  <= {8'd0, sat_b};
          end else begin
            done_a_q <= sat_a;
            shift_q  <= {8'd0, sat_a};
          end
        end
        StShift: begin
          shift_q   <= dabble_step(shift_q);
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        StStore: begin
          if (sel_b_q) begin
            tens_b_q <= shift_q[14:11];
            ones_b_q <= shift_q[10:7];
          end else begin
            tens_a_q <= shift_q[14:11];
            ones_a_q <= shift_q[10:7];
          end
        end
        default: ;
      endcase
    end
  end

  // Scan sequencing and blanking for the digit about to be shown.
  always_comb begin
    scan_wrap = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
    idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;
    seg_d     = '0;
    case (idx_d)
      2'd3: if (done_a_q != 7'd0 && tens_a_q != 4'd0) seg_d = seg7(tens_a_q);
      2'd2: if (done_a_q != 7'd0) seg_d = seg7(ones_a_q);
      2'd1: if (done_b_q != 7'd0 && tens_b_q != 4'd0) seg_d = seg7(tens_b_q);
      2'd0: if (done_b_q != 7'd0) seg_d = seg7(ones_b_q);
      default: seg_d = '0;
    endcase
  end

  // Scan counter, digit index and registered segments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= '0;
    end else begin
      scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
      idx_q      <= idx_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.lamp_a = lamp_a_q;
  assign bus.lamp_b = lamp_b_q;
  assign bus.seg    = seg_q;
  assign bus.an     = 4'b0001 << idx_q;

endmodule

// File: tb/tb_traffic_display_driver.sv
// Self-checking bench: reference model derived from the lamp/blink/display rules.
module tb_traffic_display_driver;
  localparam int unsigned SD = 2;
  localparam int unsigned BD = 8;
  localparam int unsigned BL = 3;

  logic clk = 1'b0;
  logic reset;
  traffic_display_driver_if bus ();

  traffic_display_driver #(
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD),
    .BLINK_LAST(BL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: registered phase/count as seen by the lamp stage, age since phase change.
  logic [1:0]  m_ph_a, m_prev_a, m_ph_b, m_prev_b;
  logic [31:0] m_cnt_a, m_cnt_b;
  int          m_age_a, m_age_b, m_k;
  bit          m_valid;
  logic [3:0]  exp_lamp_a, exp_lamp_b, exp_an;

  function automatic logic [6:0] pat(int d);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  // Lit for the change cycle, then BD+1.. cycles alternate starting lit.
  function automatic bit blink_on(int age);
    return (age == 0) || ((((age - 1) / int'(BD)) % 2) == 0);
  endfunction

  function automatic logic [3:0] lamp_of(logic [1:0] ph, logic [31:0] cnt, bit on);
    if (ph == 2'b00) return 4'b0001;
    if (cnt >= 1 && cnt <= BL && !on) return 4'b0000;
    return 4'b0001 << ph;
  endfunction

  function automatic logic [6:0] digit_seg(logic [31:0] cnt, bit tens);
    int v;
    v = (cnt >= 99) ? 99 : int'(cnt);
    if (v == 0) return 7'd0;
    if (tens) return (v / 10 == 0) ? 7'd0 : pat(v / 10);
    return pat(v % 10);
  endfunction

  function automatic logic [6:0] exp_seg();
    int idx;
    idx = (m_k / int'(SD)) % 4;
    case (idx)
      3: return digit_seg(m_cnt_a, 1'b1);
      2: return digit_seg(m_cnt_a, 1'b0);
      1: return digit_seg(m_cnt_b, 1'b1);
      default: return digit_seg(m_cnt_b, 1'b0);
    endcase
  endfunction

  // Advance one clock and update the model with what the DUT sampled at that edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_ph_a = 0; m_prev_a = 0; m_cnt_a = 0; m_age_a = 1;
      m_ph_b = 0; m_prev_b = 0; m_cnt_b = 0; m_age_b = 1;
      m_valid = 0; m_k = 0;
      exp_lamp_a = 0; exp_lamp_b = 0;
    end else begin
      exp_lamp_a = m_valid ? lamp_of(m_ph_a, m_cnt_a, blink_on(m_age_a)) : 4'b0000;
      exp_lamp_b = m_valid ? lamp_of(m_ph_b, m_cnt_b, blink_on(m_age_b)) : 4'b0000;
      m_valid = 1; m_k++;
      m_prev_a = m_ph_a; m_ph_a = bus.out;  m_cnt_a = bus.counter;
      m_prev_b = m_ph_b; m_ph_b = bus.out2; m_cnt_b = bus.counter2;
      m_age_a = (m_ph_a != m_prev_a) ? 0 : m_age_a + 1;
      m_age_b = (m_ph_b != m_prev_b) ? 0 : m_age_b + 1;
    end
    exp_an = 4'b0001 << ((m_k / int'(SD)) % 4);
    #1;
  endtask

  task automatic drive(logic [1:0] pa, logic [31:0] ca, logic [1:0] pb, logic [31:0] cb);
    bus.out = pa; bus.counter = ca; bus.out2 = pb; bus.counter2 = cb;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) begin
      tick();
      checks++;
      if (bus.lamp_a !== 4'b0 || bus.lamp_b !== 4'b0 || bus.seg !== 7'b0 || bus.an !== 4'b0001) begin
        errors++;
        $display("FAIL reset_state: lamp_a=%b lamp_b=%b seg=%b an=%b want 0000 0000 0000000 0001",
                 bus.lamp_a, bus.lamp_b, bus.seg, bus.an);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.lamp_a !== 4'b0000 || bus.lamp_b !== 4'b0000) begin
      errors++;
      $display("FAIL lamps_1clk: lamp_a=%b lamp_b=%b want 0000", bus.lamp_a, bus.lamp_b);
    end
    tick();
    checks++;
    if (bus.lamp_a !== 4'b0001 || bus.lamp_b !== 4'b0001) begin
      errors++;
      $display("FAIL stop_2clk: lamp_a=%b lamp_b=%b want 0001", bus.lamp_a, bus.lamp_b);
    end
    repeat (8 * SD) begin
      tick();
      checks++;
      if (bus.an !== exp_an) begin
        errors++;
        $display("FAIL scan_an: got %b want %b (k=%0d)", bus.an, exp_an, m_k);
      end
      checks++;
      if (bus.seg !== 7'b0) begin
        errors++;
        $display("FAIL idle_seg: got %b want 0000000", bus.seg);
      end
    end
  endtask

  task automatic test_phases();
    drive(2'b10, 15, 2'b00, 0);
    repeat (24) begin
      tick();
      checks++;
      if (bus.lamp_a !== exp_lamp_a || bus.lamp_b !== exp_lamp_b) begin
        errors++;
        $display("FAIL phase_lamps: got %b/%b want %b/%b", bus.lamp_a, bus.lamp_b,
                 exp_lamp_a, exp_lamp_b);
      end
    end
    checks++;
    if (bus.lamp_a !== 4'b0100 || bus.lamp_b !== 4'b0001) begin
      errors++;
      $display("FAIL forward_lamp: got %b/%b want 0100/0001", bus.lamp_a, bus.lamp_b);
    end
    repeat (4 * SD) begin
      tick();
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg()) begin
        errors++;
        $display("FAIL disp_15: an=%b seg=%b want an=%b seg=%b", bus.an, bus.seg, exp_an, exp_seg());
      end
      if (exp_an == 4'b0100) begin
        checks++;
        if (bus.seg !== 7'b1101101) begin
          errors++;
          $display("FAIL ones_5: got %b want 1101101", bus.seg);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [31:0] steps [3];
    steps = '{32'd5, 32'd3, 32'd1};
    for (int s = 0; s < 3; s++) begin
      drive(2'b11, steps[s], 2'b00, 0);
      repeat (40) begin
        tick();
        checks++;
        if (bus.lamp_a !== exp_lamp_a) begin
          errors++;
          $display("FAIL blink_cnt%0d: got %b want %b (age=%0d)", steps[s], bus.lamp_a,
                   exp_lamp_a, m_age_a);
        end
      end
      if (s == 0) begin
        checks++;
        if (bus.lamp_a !== 4'b1000) begin
          errors++;
          $display("FAIL right_steady: got %b want 1000", bus.lamp_a);
        end
      end
    end
    drive(2'b01, 20, 2'b00, 0);
    repeat (30) begin
      tick();
      checks++;
      if (bus.lamp_a !== exp_lamp_a) begin
        errors++;
        $display("FAIL left_lamp: got %b want %b", bus.lamp_a, exp_lamp_a);
      end
    end
    checks++;
    if (bus.lamp_a !== 4'b0010) begin
      errors++;
      $display("FAIL left_steady: got %b want 0010", bus.lamp_a);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vals [2];
    logic [6:0]  tens_w [2];
    logic [6:0]  ones_w [2];
    vals   = '{32'd250, 32'd7};
    tens_w = '{7'b1101111, 7'b0000000};
    ones_w = '{7'b1101111, 7'b0000111};
    for (int v = 0; v < 2; v++) begin
      drive(2'b10, vals[v], 2'b00, 0);
      repeat (24) tick();
      repeat (4 * SD) begin
        tick();
        checks++;
        if (bus.seg !== exp_seg()) begin
          errors++;
          $display("FAIL sat_disp%0d: seg=%b want %b", vals[v], bus.seg, exp_seg());
        end
        if (exp_an == 4'b1000 || exp_an == 4'b0100) begin
          checks++;
          if (bus.seg !== ((exp_an == 4'b1000) ? tens_w[v] : ones_w[v])) begin
            errors++;
            $display("FAIL sat_digit%0d: an=%b seg=%b", vals[v], exp_an, bus.seg);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(2'b00, 37, 2'b00, 64);
    repeat (22) tick();
    repeat (4 * SD) begin
      tick();
      checks++;
      if (bus.seg !== exp_seg()) begin
        errors++;
        $display("FAIL b2b_disp: an=%b seg=%b want %b", exp_an, bus.seg, exp_seg());
      end
    end
    // Road A keeps changing every 9 clk; road B must still be converted.
    drive(2'b00, 11, 2'b00, 58);
    for (int it = 0; it < 8; it++) begin
      bus.counter = 32'd11 + 32'(it * 13);
      repeat (9) begin
        tick();
        if (it >= 3 && (exp_an == 4'b0001 || exp_an == 4'b0010)) begin
          checks++;
          if (bus.seg !== exp_seg()) begin
            errors++;
            $display("FAIL alternation_b: an=%b seg=%b want %b", exp_an, bus.seg, exp_seg());
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b10, 42, 2'b00, 0);
    repeat (5) tick();
    reset = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if (bus.seg !== 7'b0 || bus.an !== 4'b0001 || bus.lamp_a !== 4'b0) begin
        errors++;
        $display("FAIL mid_reset: seg=%b an=%b lamp_a=%b want 0000000 0001 0000",
                 bus.seg, bus.an, bus.lamp_a);
      end
    end
    reset = 1'b1;
    repeat (13) tick();
    repeat (4 * SD) begin
      tick();
      checks++;
      if (bus.seg !== exp_seg()) begin
        errors++;
        $display("FAIL reconvert_42: an=%b seg=%b want %b", exp_an, bus.seg, exp_seg());
      end
      if (exp_an == 4'b1000) begin
        checks++;
        if (bus.seg !== 7'b1100110) begin
          errors++;
          $display("FAIL tens_4: got %b want 1100110", bus.seg);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  pa, pb;
    logic [31:0] ca, cb;
    for (int it = 0; it < 14; it++) begin
      pa = 2'($urandom_range(0, 3));
      pb = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ca = $urandom_range(0, BL + 2);
        1: ca = $urandom_range(0, 120);
        2: ca = $urandom;
        default: ca = 0;
      endcase
      case ($urandom_range(0, 2))
        0: cb = $urandom_range(0, BL + 2);
        1: cb = $urandom_range(0, 150);
        default: cb = $urandom;
      endcase
      drive(pa, ca, pb, cb);
      for (int c = 0; c < 40; c++) begin
        tick();
        checks++;
        if (bus.lamp_a !== exp_lamp_a || bus.lamp_b !== exp_lamp_b) begin
          errors++;
          $display("FAIL rand_lamps: got %b/%b want %b/%b (ph %b/%b cnt %0d/%0d)", bus.lamp_a,
                   bus.lamp_b, exp_lamp_a, exp_lamp_b, pa, pb, ca, cb);
        end
        if (c >= 32) begin
          checks++;
          if (bus.an !== exp_an || bus.seg !== exp_seg()) begin
            errors++;
            $display("FAIL rand_disp: an=%b seg=%b want an=%b seg=%b (cnt %0d/%0d)", bus.an,
                     bus.seg, exp_an, exp_seg(), ca, cb);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_phases();
    test_blink();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
